// File: rtl/rescale_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : rescale_frame_controller
// Purpose  : Buffers one frame of signed samples, tracks the peak magnitude,
//            picks a block-floating-point left shift at frame end and streams
//            the scaled frame out over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module rescale_frame_controller #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 480,
    parameter int MAX_SHIFT = 15,
    parameter int ADDR_W    = $clog2(FRAME_LEN),
    parameter int SHIFT_W   = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync_10ms,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               overrun,
    output logic               busy
);

    // Counter is one bit wider than ADDR_W when FRAME_LEN is a power of two,
    // so it can hold the value FRAME_LEN itself.
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_SCALE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]  peak_q, peak_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               overrun_q, overrun_d;
    logic               sync_q, sync_d;
    logic               in_ready_q, in_ready_d;

    logic [DATA_W-1:0]  buf_mem [FRAME_LEN];

    logic               w_sync_edge;
    logic               w_accept;
    logic [DATA_W-1:0]  w_in_abs;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_load;
    int                 w_bitlen;
    int                 w_shift_raw;
    logic [SHIFT_W-1:0] w_shift;

    assign w_sync_edge = sync_10ms & ~sync_q;
    assign w_accept    = (state_q == ST_FILL) & in_valid & in_ready_q;
    // Unsigned magnitude; the most negative sample maps exactly to 2^(DATA_W-1).
    assign w_in_abs    = in_data[DATA_W-1] ? (~in_data + 1'b1) : in_data;
    assign w_rd_data   = buf_mem[rd_q[ADDR_W-1:0]];
    // Refill the output register whenever it is empty or being consumed.
    assign w_load      = (state_q == ST_DRAIN) & (rd_q < n_q) & (~out_valid_q | out_ready);

    // Bit length of the peak and the clamped shift that normalises it.
    always_comb begin
        w_bitlen = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (peak_q[i]) begin
                w_bitlen = i + 1;
            end
        end
        w_shift_raw = DATA_W - 1 - w_bitlen;
        if (w_shift_raw < 0) begin
            w_shift_raw = 0;
        end
        if (w_shift_raw > MAX_SHIFT) begin
            w_shift_raw = MAX_SHIFT;
        end
        w_shift = SHIFT_W'(w_shift_raw);
    end

    // Next-state and datapath update for the FILL/SCALE/DRAIN sequencer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        n_d         = n_q;
        rd_d        = rd_q;
        peak_d      = peak_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overrun_d   = 1'b0;
        sync_d      = sync_10ms;

        case (state_q)
            ST_FILL: begin
                if (w_accept) begin
                    count_d = count_q + 1'b1;
                    if (w_in_abs > peak_q) begin
                        peak_d = w_in_abs;
                    end
                end
                if ((w_accept && (count_q == CNT_W'(FRAME_LEN - 1))) ||
                    (w_sync_edge && (w_accept || (count_q != '0)))) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                overrun_d = w_sync_edge;
                shift_d   = w_shift;
                n_d       = count_q;
                rd_d      = '0;
                state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                overrun_d = w_sync_edge;
                if (w_load) begin
                    out_data_d  = w_rd_data << shift_q;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_q == (n_q - 1'b1));
                    rd_d        = rd_q + 1'b1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = ST_FILL;
                    count_d = '0;
                    peak_d  = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        in_ready_d = (state_d == ST_FILL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            count_q     <= '0;
            n_q         <= '0;
            rd_q        <= '0;
            peak_q      <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            sync_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            n_q         <= n_d;
            rd_q        <= rd_d;
            peak_q      <= peak_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
            sync_q      <= sync_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Frame buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            buf_mem[count_q[ADDR_W-1:0]] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_shift = shift_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_FILL);

endmodule
`default_nettype wire

// File: tb/tb_rescale_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rescale_frame_controller
// Purpose  : Directed and randomized frames against a frame-level model of
//            the rescaling controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rescale_frame_controller;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 480;
    localparam int MAX_SHIFT = 15;
    localparam int SHIFT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               sync_10ms;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [SHIFT_W-1:0] out_shift;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               overrun;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;
    int smp[$];

    rescale_frame_controller #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .MAX_SHIFT(MAX_SHIFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sync_10ms(sync_10ms),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_shift(out_shift),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: shift that brings the frame peak magnitude up to DATA_W-1 bits.
    function automatic int model_shift();
        int peak = 0;
        int b    = 0;
        int s;
        foreach (smp[i]) begin
            if ((smp[i] < 0 ? -smp[i] : smp[i]) > peak) peak = (smp[i] < 0 ? -smp[i] : smp[i]);
        end
        while (b < 31 && peak >= (1 << b)) b++;
        s = DATA_W - 1 - b;
        if (s < 0) s = 0;
        if (s > MAX_SHIFT) s = MAX_SHIFT;
        return s;
    endfunction

    task automatic fill(input bit end_sync, input bit same_cycle, input bit sync_in_scale, input bit gaps);
        int  n = smp.size();
        int  guard;
        bit  ends_here;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            guard = 0;
            while (in_ready !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (guard == 20) chk("in_ready_wait", in_ready, 1);
            in_valid = 1'b1;
            in_data  = DATA_W'(smp[i]);
            if (end_sync && same_cycle && i == n - 1) sync_10ms = 1'b1;
            tick();
            in_valid  = 1'b0;
            sync_10ms = 1'b0;
            ends_here = (i == n - 1) && ((n == FRAME_LEN) || (end_sync && same_cycle));
            chk("in_ready_fill", in_ready, !ends_here);
        end
        if (end_sync && !same_cycle) begin
            sync_10ms = 1'b1;
            tick();
            sync_10ms = 1'b0;
            chk("in_ready_after_sync", in_ready, 0);
        end
        chk("busy_scale", busy, 1);
        if (sync_in_scale) begin
            sync_10ms = 1'b1;
            tick();
            sync_10ms = 1'b0;
            chk("overrun_scale", overrun, 1);
        end
    endtask

    // mode 0: out_ready always 1; 1: pattern 1,0,0,1,0,1; 2: random.
    task automatic drain(input int mode, input int sync_cyc, input int rst_after);
        int            n = smp.size();
        int            s = model_shift();
        logic [15:0]   exp_q[$];
        int            k = 0;
        int            cyc = 0;
        bit            first_seen = 0;
        int            ph;
        foreach (smp[i]) exp_q.push_back(16'(smp[i] * (1 << s)));
        while (k < n && cyc < 4000) begin
            if (rst_after >= 0 && k == rst_after) begin
                rst       = 1'b1;
                out_ready = 1'b0;
                tick();
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_out_last", out_last, 0);
                rst = 1'b0;
                tick();
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid2", out_valid, 0);
                return;
            end
            if (cyc == 2 && !first_seen) chk("first_valid", out_valid, 1);
            if (mode == 0 && first_seen) chk("stream_valid", out_valid, 1);
            if (out_valid) begin
                chk("out_data", out_data, exp_q[k]);
                chk("out_last", out_last, (k == n - 1));
                chk("out_shift", out_shift, s);
            end
            chk("in_ready_drain", in_ready, 0);
            if (sync_cyc >= 0) begin
                if (cyc == sync_cyc) sync_10ms = 1'b1;
                if (cyc == sync_cyc + 1) begin
                    sync_10ms = 1'b0;
                    chk("overrun_drain", overrun, 1);
                end
                if (cyc == sync_cyc + 2) chk("overrun_pulse_end", overrun, 0);
            end
            ph = cyc % 6;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph == 0 || ph == 3 || ph == 5);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) first_seen = 1;
            if (out_valid && out_ready) k++;
            tick();
            cyc++;
        end
        if (cyc >= 4000) chk("drain_timeout", k, n);
        out_ready = 1'b0;
        sync_10ms = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int n;
        int k;
        int mag;
        int v;
        rst       = 1'b1;
        sync_10ms = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_shift", out_shift, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("release_in_ready", in_ready, 1);

        // Sync edge with an empty frame is ignored.
        sync_10ms = 1'b1;
        tick();
        sync_10ms = 1'b0;
        chk("empty_sync_overrun", overrun, 0);
        chk("empty_sync_busy", busy, 0);
        chk("empty_sync_in_ready", in_ready, 1);
        tick();

        // Full frame, overrun sync during SCALE.
        smp.delete();
        for (int i = 0; i < FRAME_LEN; i++) smp.push_back(i - 240);
        fill(0, 0, 1, 1);
        drain(0, -1, -1);

        // Short frame, sync after last accept, then on the same cycle.
        smp = '{100, -200, 50};
        fill(1, 0, 0, 1);
        drain(2, -1, -1);
        fill(1, 1, 0, 0);
        drain(0, -1, -1);

        // Peak cases.
        smp = '{5, -32768, 1000, -7};
        fill(1, 0, 0, 1);
        drain(2, -1, -1);
        smp = '{0, 0, 0, 0};
        fill(1, 1, 0, 0);
        drain(0, -1, -1);
        smp = '{16383, -3, 0};
        fill(1, 0, 0, 0);
        drain(2, -1, -1);

        // Backpressure pattern on a 10-sample frame with a sync during DRAIN.
        smp.delete();
        for (int i = 0; i < 10; i++) smp.push_back($urandom_range(0, 4000) - 2000);
        fill(1, 0, 0, 1);
        drain(1, 3, -1);

        // Reset in the middle of DRAIN, then a tiny frame.
        smp.delete();
        for (int i = 0; i < 10; i++) smp.push_back($urandom_range(0, 600) - 300);
        fill(1, 1, 0, 0);
        drain(0, -1, 5);
        smp = '{1, -1};
        fill(1, 0, 0, 0);
        drain(0, -1, -1);

        // Full frame whose final accept coincides with a sync edge.
        smp.delete();
        for (int i = 0; i < FRAME_LEN; i++) smp.push_back($urandom_range(0, 2000) - 1000);
        fill(1, 1, 0, 0);
        drain(2, -1, -1);

        // Random frames.
        for (int f = 0; f < 20; f++) begin
            smp.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                k   = $urandom_range(0, 15);
                mag = $urandom_range(0, (1 << k) - 1);
                v   = ($urandom_range(0, 1) == 1) ? -mag : mag;
                if (k == 15 && $urandom_range(0, 7) == 0) v = -32768;
                smp.push_back(v);
            end
            fill(1, 1'($urandom_range(0, 1)), 0, 1);
            drain(2, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
